instr_encoder_loader: RTL and testbench

- Encoder counterpart to the main-decoder opcode set. Accepts RV32I instruction fields over a valid/ready handshake.
- Supported formats: R-type (0110011), load (0000011), store (0100011) and branch (1100011).
- Packs the fields into 32-bit machine words and writes them sequentially into instruction memory.
- Used by the bench and by the boot path to preload programs for the single-cycle core.

---
 rtl/instr_encoder_loader_if.sv | 28 ++
 rtl/instr_encoder_loader.sv | 131 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake and instruction-memory write bus of the encoder/loader.
// The slave side is the encoder; the master side feeds bundles and observes writes.
interface instr_encoder_loader_if #(
   parameter int ADDR_W = 6
) ();
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_fmt;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [12:0]       imm;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport slave (
      input  in_valid, in_fmt, rd, rs1, rs2, funct3, funct7, imm,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport master (
      output in_valid, in_fmt, rd, rs1, rs2, funct3, funct7, imm,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I encoder/loader: packs R/load/store/branch field bundles into machine
// words and writes them sequentially into instruction memory (one word per
// two cycles), stopping when the memory is full until start clears it.
module instr_encoder_loader #(
   parameter int ADDR_W    = 6,
   parameter int CHECK_IMM = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   instr_encoder_loader_if.slave bus,
   output logic [ADDR_W:0]     count,
   output logic                full,
   output logic                err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [1:0] FMT_R      = 2'b00;
   localparam logic [1:0] FMT_LOAD   = 2'b01;
   localparam logic [1:0] FMT_STORE  = 2'b10;
   localparam logic [1:0] FMT_BRANCH = 2'b11;

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   count_q;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [31:0]       imem_wdata_q;
   logic              err_q;

   logic [31:0]       enc_word;
   logic              imm_bad;
   logic              accept;
   logic [ADDR_W:0]   count_inc;

   // Pack the current field bundle into a 32-bit RV32I word.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      enc_word = 32'd0;
      unique case (bus.in_fmt)
         FMT_R:      enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
         FMT_LOAD:   enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0000011};
         FMT_STORE:  enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                                 bus.imm[4:0], 7'b0100011};
         FMT_BRANCH: enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                                 bus.imm[4:1], bus.imm[11], 7'b1100011};
         default:    enc_word = 32'd0;
      endcase
   end

   // Immediate legality: 12-bit signed for load/store, even offset for branch.
   always_comb begin
      imm_bad = 1'b0;
      if (CHECK_IMM != 0) begin
         unique case (bus.in_fmt)
            FMT_LOAD, FMT_STORE: imm_bad = (bus.imm[12] != bus.imm[11]);
            FMT_BRANCH:          imm_bad = bus.imm[0];
            default:             imm_bad = 1'b0;
         endcase
      end
   end

   // in_ready is combinational on start so a bundle offered alongside start is never taken.
   assign bus.in_ready = rst_n && (state == IDLE) && !start;
   assign accept       = bus.in_valid && bus.in_ready;
   assign count_inc    = count_q + 1'b1;

   // Handshake/write FSM with registered write strobe, address, data and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptr          <= '0;
         count_q      <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= 32'd0;
         err_q        <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         imem_we_q <= 1'b0;
         err_q     <= 1'b0;
         if (start) begin
            // A write already on the bus this cycle completes; only the bookkeeping is cleared.
            state   <= IDLE;
            ptr     <= '0;
            count_q <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (accept) begin
                     if (imm_bad) begin
                        err_q <= 1'b1;
                     end else begin
                        imem_wdata_q <= enc_word;
                        imem_addr_q  <= ptr;
                        imem_we_q    <= 1'b1;
                        state        <= WRITE;
                     end
                  end
               end
               WRITE: begin
                  ptr     <= ptr + 1'b1;
                  count_q <= count_inc;
                  state   <= (count_inc == DEPTH) ? FULL : IDLE;
               end
               FULL: begin
                  state <= FULL;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign count          = count_q;
   assign full           = (state == FULL);
   assign err            = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: scoreboard of expected
// (address, word) writes, popped by a monitor on every imem_we cycle.
module tb_instr_encoder_loader;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t               exp_q[$];
   logic [ADDR_W-1:0] exp_ptr;
   int                exp_count;

   instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

   instr_encoder_loader #(.ADDR_W(ADDR_W), .CHECK_IMM(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bus   (bus),
      .count (count),
      .full  (full),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference encoder built from the RV32I field layout.
   function automatic logic [31:0] ref_encode(input logic [1:0] fmt, input logic [4:0] rd_v,
                                              input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [12:0] iv);
      logic [31:0] w;
      w = 32'd0;
      w[14:12] = f3;
      w[19:15] = rs1_v;
      case (fmt)
         2'b00: begin w[6:0] = 7'h33; w[11:7] = rd_v; w[24:20] = rs2_v; w[31:25] = f7; end
         2'b01: begin w[6:0] = 7'h03; w[11:7] = rd_v; w[31:20] = iv[11:0]; end
         2'b10: begin w[6:0] = 7'h23; w[11:7] = iv[4:0]; w[24:20] = rs2_v; w[31:25] = iv[11:5]; end
         default: begin
            w[6:0] = 7'h63; w[7] = iv[11]; w[11:8] = iv[4:1];
            w[24:20] = rs2_v; w[30:25] = iv[10:5]; w[31] = iv[12];
         end
      endcase
      return w;
   endfunction

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         wr_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%h", bus.imem_addr, bus.imem_wdata);
         end else begin
            e = exp_q.pop_front();
            if (bus.imem_addr !== e.addr || bus.imem_wdata !== e.data) begin
               errors++;
               $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                        bus.imem_addr, bus.imem_wdata, e.addr, e.data);
            end
         end
      end
   end

   task automatic idle_inputs();
      bus.in_valid = 1'b0;
      bus.in_fmt   = 2'b00;
      bus.rd       = 5'd0;
      bus.rs1      = 5'd0;
      bus.rs2      = 5'd0;
      bus.funct3   = 3'd0;
      bus.funct7   = 7'd0;
      bus.imm      = 13'd0;
   endtask

   // Offer one bundle until accepted (bounded); returns at accept edge + 1.
   task automatic send(input logic [1:0] fmt, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                       input logic [4:0] rs2_v, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [12:0] iv, input logic good, input logic [31:0] word);
      int waited;
      @(negedge clk);
      bus.in_fmt = fmt; bus.rd = rd_v; bus.rs1 = rs1_v; bus.rs2 = rs2_v;
      bus.funct3 = f3; bus.funct7 = f7; bus.imm = iv; bus.in_valid = 1'b1;
      waited = 0;
      while (bus.in_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (bus.in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout in_ready=%b want 1", bus.in_ready);
         bus.in_valid = 1'b0;
      end else begin
         if (good) begin
            exp_q.push_back('{addr: exp_ptr, data: word});
            exp_ptr++;
            exp_count++;
         end
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      idle_inputs();
      exp_ptr = '0;
      exp_count = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.imem_we, err, full, bus.in_ready} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got we/err/full/rdy=%b want 0000",
                  {bus.imem_we, err, full, bus.in_ready});
      end
      checks++;
      if (count !== '0 || bus.imem_addr !== '0 || bus.imem_wdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_regs count=%0d addr=%0d data=%h want 0", count, bus.imem_addr,
                  bus.imem_wdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_rtype();
      send(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, 32'h002081B3);
      checks++;
      if (bus.imem_we !== 1'b1 || bus.imem_addr !== 6'd0) begin
         errors++;
         $display("FAIL rtype_strobe we=%b addr=%0d want 1/0", bus.imem_we, bus.imem_addr);
      end
      @(posedge clk);
      #1;
      checks++;
      if (count !== 7'd1 || bus.imem_we !== 1'b0) begin
         errors++;
         $display("FAIL rtype_count count=%0d we=%b want 1/0", count, bus.imem_we);
      end
   endtask

   task automatic test_load_store();
      send(2'b01, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8, 1'b1, 32'h00812283);
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_in_write_ld got %b want 0", bus.in_ready);
      end
      send(2'b10, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 13'h1FFC, 1'b1, 32'hFE512E23);
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_in_write_st got %b want 0", bus.in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (count !== 7'd3) begin
         errors++;
         $display("FAIL ldst_count got %0d want 3", count);
      end
   endtask

   task automatic test_branch();
      send(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8, 1'b1, 32'hFE208CE3);
      @(posedge clk);
      #1;
      checks++;
      if (count !== 7'd4) begin
         errors++;
         $display("FAIL branch_count got %0d want 4", count);
      end
   endtask

   task automatic test_errors();
      logic [12:0] bad_imm [2];
      logic [1:0]  bad_fmt [2];
      bad_imm[0] = 13'd5;     bad_fmt[0] = 2'b11;
      bad_imm[1] = 13'h0800;  bad_fmt[1] = 2'b01;
      for (int i = 0; i < 2; i++) begin
         send(bad_fmt[i], 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, bad_imm[i], 1'b0, 32'd0);
         checks++;
         if (err !== 1'b1 || bus.imem_we !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_%0d err=%b we=%b want 1/0", i, err, bus.imem_we);
         end
         @(posedge clk);
         #1;
         checks++;
         if (err !== 1'b0 || count !== 7'd4 || bus.imem_we !== 1'b0) begin
            errors++;
            $display("FAIL err_after_%0d err=%b count=%0d we=%b want 0/4/0", i, err, count,
                     bus.imem_we);
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_ptr = '0;
      exp_count = 0;
   endtask

   task automatic test_fill_and_start();
      logic [1:0]  fmt;
      logic [4:0]  a, b, c;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [12:0] iv;
      pulse_start();
      checks++;
      if (count !== '0 || full !== 1'b0) begin
         errors++;
         $display("FAIL start_clear count=%0d full=%b want 0/0", count, full);
      end
      for (int i = 0; i < DEPTH; i++) begin
         fmt = 2'($urandom_range(0, 3));
         a = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
         f3 = 3'($urandom); f7 = 7'($urandom);
         iv = 13'($urandom);
         if (fmt == 2'b11) iv[0] = 1'b0;
         else iv[12] = iv[11];
         send(fmt, a, b, c, f3, f7, iv, 1'b1, ref_encode(fmt, a, b, c, f3, f7, iv));
      end
      @(posedge clk);
      #1;
      checks++;
      if (full !== 1'b1 || count !== 7'(DEPTH) || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_state full=%b count=%0d rdy=%b want 1/%0d/0", full, count,
                  bus.in_ready, DEPTH);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_fmt = 2'b00;
      repeat (5) @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || count !== 7'(DEPTH)) begin
         errors++;
         $display("FAIL full_refuses rdy=%b count=%0d want 0/%0d", bus.in_ready, count, DEPTH);
      end
      bus.in_valid = 1'b0;
      pulse_start();
      checks++;
      if (count !== '0 || full !== 1'b0) begin
         errors++;
         $display("FAIL restart count=%0d full=%b want 0/0", count, full);
      end
      send(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, 32'h002081B3);
      checks++;
      if (bus.imem_addr !== 6'd0) begin
         errors++;
         $display("FAIL restart_addr got %0d want 0", bus.imem_addr);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_write();
      send(2'b00, 5'd7, 5'd6, 5'd5, 3'd1, 7'd0, 13'd0, 1'b1, ref_encode(2'b00, 5'd7, 5'd6,
           5'd5, 3'd1, 7'd0, 13'd0));
      checks++;
      if (bus.imem_we !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_we got %b want 1", bus.imem_we);
      end
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      exp_ptr = '0;
      exp_count = 0;
      #1;
      checks++;
      if (bus.imem_we !== 1'b0 || count !== '0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset we=%b count=%0d rdy=%b want 0/0/0", bus.imem_we, count,
                  bus.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_start_mid_write();
      send(2'b01, 5'd9, 5'd8, 5'd0, 3'd2, 7'd0, 13'd16, 1'b1, 32'h01042483);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_ptr = '0;
      exp_count = 0;
      checks++;
      if (count !== '0 || bus.imem_we !== 1'b0) begin
         errors++;
         $display("FAIL start_mid_write count=%0d we=%b want 0/0", count, bus.imem_we);
      end
      send(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, 32'h002081B3);
      @(posedge clk);
      #1;
      checks++;
      if (count !== 7'd1) begin
         errors++;
         $display("FAIL after_start_count got %0d want 1", count);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_load_store();
      test_branch();
      test_errors();
      test_fill_and_start();
      test_reset_mid_write();
      test_start_mid_write();
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "time limit");
   end
endmodule
